// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares one single-ported unified memory between the core's instruction
// fetch port and its data (MA stage) port. One transaction is outstanding at
// a time. The winner's command is registered onto the mem_* outputs and held
// until the memory answers with mem_ready. The read data is then registered
// into the granted port's data output, and that port's ready output pulses
// for one cycle.
//
// Grant policy:
//   default build      : data has fixed priority over fetch. A starvation
//                        counter lets a pending fetch win after
//                        MAX_DATA_GRANTS consecutive data grants.
//   MEM_ARB_ROUND_ROBIN_EN defined
//                      : round robin. When both ports request, the port
//                        not granted last wins. The counter stays at zero.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clk_en              clock enable; when low, all state and outputs hold
//   inst_rd_en          fetch request
//   inst_addr           fetch byte address
//   inst_data           fetched word (held between transactions)
//   inst_ready          fetch complete, one-cycle pulse
//   data_rd_en          load request
//   data_wr_en          store request (wins if data_rd_en is also high)
//   data_addr           load/store byte address
//   data_wr             store data
//   data_rd_wr_ctrl     access size: 00 byte, 01 half, 10 word
//   data_rd             load data (held between transactions)
//   data_ready          load/store complete, one-cycle pulse
//   mem_rd_en           memory read command
//   mem_wr_en           memory write command
//   mem_addr            memory byte address
//   mem_wdata           memory write data
//   mem_size            memory access size
//   mem_rdata           memory read data, valid while mem_ready is high
//   mem_ready           memory transaction complete
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_GRANTS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,

    input  logic                  inst_rd_en,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  inst_ready,

    input  logic                  data_rd_en,
    input  logic                  data_wr_en,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic [1:0]            data_rd_wr_ctrl,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  data_ready,

    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_INST_BUSY = 2'd1;
    localparam logic [1:0] ST_DATA_BUSY = 2'd2;

    localparam logic       GRANT_INST   = 1'b0;
    localparam logic       GRANT_DATA   = 1'b1;

    localparam logic [1:0] SIZE_WORD    = 2'b10;

`ifndef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [3:0] MAX_CNT      = 4'(MAX_DATA_GRANTS);
`endif

    logic [1:0]            state_q,      state_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  last_grant_q, last_grant_d;

    logic                  mem_rd_en_q,  mem_rd_en_d;
    logic                  mem_wr_en_q,  mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic [1:0]            mem_size_q,   mem_size_d;

    logic [DATA_WIDTH-1:0] inst_data_q,  inst_data_d;
    logic                  inst_ready_q, inst_ready_d;
    logic [DATA_WIDTH-1:0] data_rd_q,    data_rd_d;
    logic                  data_ready_q, data_ready_d;

    logic                  data_req;
    logic                  grant_inst;
    logic                  grant_data;
    logic [3:0]            starve_cnt_next;

    // Decide which port would win if the FSM were in IDLE this cycle. The
    // result is only acted on in IDLE, so the BUSY states ignore requests.
    always_comb begin
        data_req        = data_rd_en | data_wr_en;
        grant_inst      = 1'b0;
        grant_data      = 1'b0;
        starve_cnt_next = starve_cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (inst_rd_en && data_req) begin
            if (last_grant_q == GRANT_DATA) begin
                grant_inst = 1'b1;
            end else begin
                grant_data = 1'b1;
            end
        end else begin
            grant_inst = inst_rd_en;
            grant_data = data_req;
        end
        starve_cnt_next = 4'd0;
`else
        // A pending fetch overrides data priority once the counter reaches
        // the limit.
        if (inst_rd_en && (!data_req || (starve_cnt_q == MAX_CNT))) begin
            grant_inst = 1'b1;
        end else begin
            grant_data = data_req;
        end

        // The counter counts only data grants that made a fetch wait. It
        // saturates at the limit.
        if (grant_inst) begin
            starve_cnt_next = 4'd0;
        end else if (grant_data) begin
            if (!inst_rd_en) begin
                starve_cnt_next = 4'd0;
            end else if (starve_cnt_q != MAX_CNT) begin
                starve_cnt_next = starve_cnt_q + 4'd1;
            end
        end
`endif
    end

    // Next-state logic. When clk_en is low, every register keeps its value,
    // including the ready pulses and the mem_ready sampling.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        last_grant_d = last_grant_q;
        mem_rd_en_d  = mem_rd_en_q;
        mem_wr_en_d  = mem_wr_en_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        inst_data_d  = inst_data_q;
        inst_ready_d = inst_ready_q;
        data_rd_d    = data_rd_q;
        data_ready_d = data_ready_q;

        if (clk_en) begin
            inst_ready_d = 1'b0;
            data_ready_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // mem_ready seen here belongs to no transaction and is
                    // ignored.
                    starve_cnt_d = starve_cnt_next;
                    mem_rd_en_d  = 1'b0;
                    mem_wr_en_d  = 1'b0;
                    if (grant_data) begin
                        // A store wins if load and store are both asserted.
                        mem_rd_en_d  = ~data_wr_en;
                        mem_wr_en_d  = data_wr_en;
                        mem_addr_d   = data_addr;
                        mem_wdata_d  = data_wr;
                        mem_size_d   = data_rd_wr_ctrl;
                        last_grant_d = GRANT_DATA;
                        state_d      = ST_DATA_BUSY;
                    end else if (grant_inst) begin
                        mem_rd_en_d  = 1'b1;
                        mem_addr_d   = inst_addr;
                        mem_wdata_d  = '0;
                        mem_size_d   = SIZE_WORD;
                        last_grant_d = GRANT_INST;
                        state_d      = ST_INST_BUSY;
                    end
                end

                ST_INST_BUSY: begin
                    if (mem_ready) begin
                        mem_rd_en_d  = 1'b0;
                        mem_wr_en_d  = 1'b0;
                        inst_data_d  = mem_rdata;
                        inst_ready_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end

                ST_DATA_BUSY: begin
                    if (mem_ready) begin
                        // A store completes without changing data_rd.
                        if (!mem_wr_en_q) begin
                            data_rd_d = mem_rdata;
                        end
                        mem_rd_en_d  = 1'b0;
                        mem_wr_en_d  = 1'b0;
                        data_ready_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end

                default: begin
                    mem_rd_en_d = 1'b0;
                    mem_wr_en_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers. Reset drops any command in flight at once,
    // and no ready pulse is issued for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= 4'd0;
            last_grant_q <= GRANT_DATA;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= 2'b00;
            inst_data_q  <= '0;
            inst_ready_q <= 1'b0;
            data_rd_q    <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            last_grant_q <= last_grant_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            inst_data_q  <= inst_data_d;
            inst_ready_q <= inst_ready_d;
            data_rd_q    <= data_rd_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign mem_rd_en  = mem_rd_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_size   = mem_size_q;
    assign inst_data  = inst_data_q;
    assign inst_ready = inst_ready_q;
    assign data_rd    = data_rd_q;
    assign data_ready = data_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Directed bench for mem_port_arbiter. The main sequence drives the requesters
// and plays the memory. For each request it pushes the expected memory
// command and the expected response onto two queues. Two monitors pop those
// queues when the DUT issues a command or a ready pulse.
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } cmd_t;

    typedef struct packed {
        logic        is_inst;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        inst_rd_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        data_rd_en;
    logic        data_wr_en;
    logic [31:0] data_addr;
    logic [31:0] data_wr;
    logic [1:0]  data_rd_wr_ctrl;
    logic [31:0] data_rd;
    logic        data_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    cmd_t        cmd_q[$];
    resp_t       resp_q[$];
    logic [31:0] exp_data_rd;

    mem_port_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_DATA_GRANTS (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .inst_rd_en      (inst_rd_en),
        .inst_addr       (inst_addr),
        .inst_data       (inst_data),
        .inst_ready      (inst_ready),
        .data_rd_en      (data_rd_en),
        .data_wr_en      (data_wr_en),
        .data_addr       (data_addr),
        .data_wr         (data_wr),
        .data_rd_wr_ctrl (data_rd_wr_ctrl),
        .data_rd         (data_rd),
        .data_ready      (data_ready),
        .mem_rd_en       (mem_rd_en),
        .mem_wr_en       (mem_wr_en),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_size        (mem_size),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready)
    );

    // 10 ns clock; the posedge count is used to measure latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it and reports tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives every requester input at once.
    task automatic applyStimulus(input logic i_en, input logic [31:0] i_addr,
                                 input logic d_rd, input logic d_wr, input logic [31:0] d_addr,
                                 input logic [31:0] d_wdata, input logic [1:0] d_size);
        inst_rd_en      = i_en;
        inst_addr       = i_addr;
        data_rd_en      = d_rd;
        data_wr_en      = d_wr;
        data_addr       = d_addr;
        data_wr         = d_wdata;
        data_rd_wr_ctrl = d_size;
    endtask

    task automatic pushCmd(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = addr; c.wdata = wdata; c.size = size;
        cmd_q.push_back(c);
    endtask

    task automatic pushResp(input logic is_inst, input logic [31:0] data);
        resp_t r;
        r.is_inst = is_inst; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_inst_data"}, inst_data, 32'h0);
        checkOutput({tag, "_data_rd"}, data_rd, 32'h0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, "_ctl"}, 32'({inst_ready, data_ready, mem_rd_en, mem_wr_en, mem_size}), 32'h0);
    endtask

    // Waits, with a bound, for a memory command to appear.
    task automatic waitCmd();
        int n = 0;
        while (!(mem_rd_en || mem_wr_en) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_issued", 32'(mem_rd_en || mem_wr_en), 32'h1);
    endtask

    // Plays the memory for one transaction. Returns at the negedge where the
    // ready pulse is visible.
    task automatic serveOne(input int waits, input logic [31:0] rdata);
        waitCmd();
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
    endtask

    // Command monitor: a new command must match the head of the queue, and a
    // command must hold stable while it is outstanding.
    cmd_t cur_cmd;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        cmd_t obs;
        cmd_t e;
        obs.rd = mem_rd_en; obs.wr = mem_wr_en; obs.addr = mem_addr;
        obs.wdata = mem_wdata; obs.size = mem_size;
        if ((mem_rd_en || mem_wr_en) && !prev_en) begin
            checkOutput("cmd_expected", 32'(cmd_q.size() != 0), 32'h1);
            if (cmd_q.size() != 0) begin
                e = cmd_q.pop_front();
                checkOutput("cmd_rdwr_size", 32'({obs.rd, obs.wr, obs.size}), 32'({e.rd, e.wr, e.size}));
                checkOutput("cmd_addr", obs.addr, e.addr);
                checkOutput("cmd_wdata", obs.wdata, e.wdata);
            end
            cur_cmd = obs;
        end else if ((mem_rd_en || mem_wr_en) && prev_en) begin
            checkOutput("cmd_hold_addr", obs.addr, cur_cmd.addr);
            checkOutput("cmd_hold_ctl", 32'({obs.rd, obs.wr, obs.size, obs.wdata[7:0]}),
                        32'({cur_cmd.rd, cur_cmd.wr, cur_cmd.size, cur_cmd.wdata[7:0]}));
        end
        prev_en = mem_rd_en || mem_wr_en;
    end

    // Response monitor: every cycle with a ready high consumes one expected
    // response, so a stretched or spurious pulse finds an empty queue.
    always @(negedge clk) begin
        resp_t r;
        if (inst_ready || data_ready) begin
            checkOutput("resp_expected", 32'(resp_q.size() != 0), 32'h1);
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                checkOutput("resp_port", 32'(inst_ready), 32'(r.is_inst));
                if (r.is_inst) checkOutput("inst_data", inst_data, r.data);
                else           checkOutput("data_rd", data_rd, r.data);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int t0;
        logic [1:0] order [6];
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        exp_data_rd = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);

        // Reset state.
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Zero-wait fetch.
        @(negedge clk);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        pushCmd(1'b1, 1'b0, 32'h100, 32'h0, 2'b10);
        pushResp(1'b1, 32'h00A00093);
        t0 = cyc;
        serveOne(0, 32'h00A00093);
        checkOutput("fetch_ready", 32'(inst_ready), 32'h1);
        checkOutput("fetch_latency", 32'(cyc - t0), 32'd2);
        inst_rd_en = 1'b0;

        // Simultaneous fetch and load: the load goes first.
        @(negedge clk);
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 2'b10);
        pushCmd(1'b1, 1'b0, 32'h2000, 32'h0, 2'b10);
        pushCmd(1'b1, 1'b0, 32'h104, 32'h0, 2'b10);
        pushResp(1'b0, 32'hCAFE0001);
        pushResp(1'b1, 32'h00100113);
        t0 = cyc;
        serveOne(0, 32'hCAFE0001);
        exp_data_rd = 32'hCAFE0001;
        checkOutput("simul_data_ready", 32'(data_ready), 32'h1);
        checkOutput("simul_data_latency", 32'(cyc - t0), 32'd2);
        data_rd_en = 1'b0;
        t0 = cyc;
        serveOne(0, 32'h00100113);
        checkOutput("simul_inst_latency", 32'(cyc - t0), 32'd2);
        inst_rd_en = 1'b0;

        // Byte store: data_rd keeps the last load value.
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2010, 32'hAB, 2'b00);
        pushCmd(1'b0, 1'b1, 32'h2010, 32'hAB, 2'b00);
        pushResp(1'b0, exp_data_rd);
        serveOne(0, 32'h12345678);
        data_wr_en = 1'b0;
        checkOutput("store_data_rd_kept", data_rd, exp_data_rd);

        // Load and store together: issued as a half-word store.
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2012, 32'hBEEF, 2'b01);
        pushCmd(1'b0, 1'b1, 32'h2012, 32'hBEEF, 2'b01);
        pushResp(1'b0, exp_data_rd);
        serveOne(0, 32'h87654321);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);

        // 3 wait states plus 2 cycles of clk_en=0. A mem_ready during the
        // frozen cycle must not be sampled.
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0, 2'b10);
        pushCmd(1'b1, 1'b0, 32'h2004, 32'h0, 2'b10);
        pushResp(1'b0, 32'h0BADF00D);
        t0 = cyc;
        @(negedge clk);
        checkOutput("wait_cmd_rd", 32'(mem_rd_en), 32'h1);
        @(negedge clk);
        clk_en = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        clk_en = 1'b1;
        checkOutput("wait_no_early_ready", 32'(data_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        exp_data_rd = 32'h0BADF00D;
        checkOutput("wait_data_ready", 32'(data_ready), 32'h1);
        checkOutput("wait_latency", 32'(cyc - t0), 32'd7);
        data_rd_en = 1'b0;

        // mem_ready in IDLE is ignored; a following fetch still takes 2 cycles.
        @(negedge clk);
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        checkOutput("idle_ready_ignored", 32'({inst_ready, data_ready, mem_rd_en, mem_wr_en}), 32'h0);
        applyStimulus(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        pushCmd(1'b1, 1'b0, 32'h108, 32'h0, 2'b10);
        pushResp(1'b1, 32'h00208113);
        t0 = cyc;
        serveOne(0, 32'h00208113);
        checkOutput("idle_fetch_latency", 32'(cyc - t0), 32'd2);
        inst_rd_en = 1'b0;

        // Starvation guard, or alternation in the round-robin build. Reset
        // first so the counter and last-grant flag start from known values.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_data_rd = 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        order = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
`else
        order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
`endif
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 32'h3000, 32'h55, 2'b10);
        for (int i = 0; i < 6; i++) begin
            if (order[i] == 2'd1) begin
                pushCmd(1'b1, 1'b0, 32'h200, 32'h0, 2'b10);
                pushResp(1'b1, 32'h00000013 + 32'(i));
            end else begin
                pushCmd(1'b0, 1'b1, 32'h3000, 32'h55, 2'b10);
                pushResp(1'b0, exp_data_rd);
            end
        end
        for (int i = 0; i < 6; i++) begin
            serveOne(0, 32'h00000013 + 32'(i));
            if (i == 4) inst_rd_en = 1'b0;
            if (i == 5) data_wr_en = 1'b0;
        end

        // Reset during a store: the command drops at once and no ready pulse
        // follows.
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2020, 32'h77, 2'b10);
        pushCmd(1'b0, 1'b1, 32'h2020, 32'h77, 2'b10);
        waitCmd();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_en", 32'({mem_rd_en, mem_wr_en}), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        checkAllZero("rst_mid");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_no_ready", 32'({inst_ready, data_ready, mem_rd_en, mem_wr_en}), 32'h0);
        end

        // Every expected command and response must have been consumed.
        checkOutput("cmd_q_drained", 32'(cmd_q.size()), 32'h0);
        checkOutput("resp_q_drained", 32'(resp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
